// File: rtl/calc_pkg.sv
// rtl/calc_pkg.sv - shared key codes, operator and state encodings for the calculator core
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'hA;
    localparam logic [3:0] KEY_SUB = 4'hB;
    localparam logic [3:0] KEY_MUL = 4'hC;
    localparam logic [3:0] KEY_EQ  = 4'hD;
    localparam logic [3:0] KEY_CE  = 4'hE;
    localparam logic [3:0] KEY_AC  = 4'hF;

    typedef enum logic [1:0] {
        OP_NONE = 2'd0,
        OP_ADD  = 2'd1,
        OP_SUB  = 2'd2,
        OP_MUL  = 2'd3
    } op_e;

    typedef enum logic {
        ST_ENTRY   = 1'b0,
        ST_MUL_RUN = 1'b1
    } state_e;

    // Operator a key leaves pending; equals (and anything else) leaves none.
    function automatic op_e key_to_op(input logic [3:0] code);
        case (code)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/calc_mul_seq.sv
// rtl/calc_mul_seq.sv - unsigned WIDTH x WIDTH iterative shift-add multiplier
// clk/rst: clock, synchronous active-high reset (aborts a running multiply)
// start/a/b: one-cycle start pulse with unsigned operands
// done/product: one-cycle pulse WIDTH-1 cycles after start, product valid while done is high
module calc_mul_seq #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
    logic               running;

    // Bit 0 of b is consumed on the start edge so that the remaining WIDTH-1
    // bits finish one cycle early; the core then completes on the following
    // edge, giving exactly WIDTH busy cycles at the core.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                mcand   <= {{WIDTH{1'b0}}, a} << 1;
                mplier  <= b >> 1;
                product <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                cnt     <= '0;
                running <= 1'b1;
            end else if (running) begin
                if (mplier[0]) begin
                    product <= product + mcand;
                end
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt + 1'b1;
                if (cnt == CW'(WIDTH - 2)) begin
                    running <= 1'b0;
                    done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/calc_core_param.sv
// rtl/calc_core_param.sv - keypad calculator core with chained signed add/sub/mul
// clk/rst: clock, synchronous active-high reset
// key_valid/key_code: held key level and its 4-bit keypad code
// display/neg: current entry or last result (two's complement) and its sign bit
// ovf/busy/op_pend: sticky overflow, multiply in progress, pending operator
module calc_core_param
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MUL_ENABLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_valid,
    input  logic [3:0]       key_code,
    output logic [WIDTH-1:0] display,
    output logic             neg,
    output logic             ovf,
    output logic             busy,
    output logic [1:0]       op_pend
);
    localparam logic [WIDTH+3:0]   ENTRY_MAX = (WIDTH+4)'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic [2*WIDTH-1:0] POS_LIM   = (2*WIDTH)'((64'd1 << (WIDTH-1)) - 64'd1);
    localparam logic [2*WIDTH-1:0] NEG_LIM   = (2*WIDTH)'(64'd1 << (WIDTH-1));

    state_e             state;
    op_e                pend_op;
    op_e                fin_pend;
    logic               key_q;
    logic               fresh;
    logic               fin_eq;
    logic               mul_neg;
    logic [WIDTH-1:0]   entry;
    logic [WIDTH-1:0]   operand;

    logic               key_ev;
    logic               is_digit;
    logic               is_op;
    logic               is_eq;
    logic               correction;
    op_e                next_op;
    logic [WIDTH+3:0]   digit_acc;
    logic               digit_ok;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   addsub_res;
    logic               addsub_ovf;
    logic               mul_start;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [2*WIDTH-1:0] mul_signed;
    logic [WIDTH-1:0]   mul_res;
    logic               mul_ovf;

    assign key_ev     = key_valid & ~key_q;
    assign is_digit   = (key_code <= 4'd9);
    assign is_eq      = (key_code == KEY_EQ);
    assign is_op      = (key_code == KEY_ADD) || (key_code == KEY_SUB) || is_eq ||
                        ((key_code == KEY_MUL) && (MUL_ENABLE != 0));
    assign next_op    = key_to_op(key_code);
    // An operator straight after another operator only swaps the pending op.
    assign correction = fresh && (pend_op != OP_NONE);

    // entry is never negative while fresh is low, so unsigned accumulation is safe.
    assign digit_acc  = ({4'b0000, entry} * (WIDTH+4)'(10)) + {{WIDTH{1'b0}}, key_code};
    assign digit_ok   = (digit_acc <= ENTRY_MAX);

    assign sum        = operand + entry;
    assign diff       = operand - entry;
    assign addsub_res = (pend_op == OP_SUB) ? diff : sum;
    assign addsub_ovf = (pend_op == OP_SUB)
                      ? ((operand[WIDTH-1] != entry[WIDTH-1]) && (diff[WIDTH-1] != operand[WIDTH-1]))
                      : ((operand[WIDTH-1] == entry[WIDTH-1]) && (sum[WIDTH-1] != operand[WIDTH-1]));

    // Magnitudes fit in WIDTH unsigned bits, including the most negative value.
    assign mul_a      = operand[WIDTH-1] ? (~operand + 1'b1) : operand;
    assign mul_b      = entry[WIDTH-1]   ? (~entry + 1'b1)   : entry;
    assign mul_start  = (state == ST_ENTRY) && key_ev && is_op && !correction &&
                        (pend_op == OP_MUL);
    assign mul_signed = mul_neg ? (~mul_product + 1'b1) : mul_product;
    assign mul_res    = mul_signed[WIDTH-1:0];
    assign mul_ovf    = mul_neg ? (mul_product > NEG_LIM) : (mul_product > POS_LIM);

    generate
        if (MUL_ENABLE != 0) begin : g_mul
            calc_mul_seq #(
                .WIDTH   (WIDTH)
            ) u_mul (
                .clk     (clk),
                .rst     (rst),
                .start   (mul_start),
                .a       (mul_a),
                .b       (mul_b),
                .done    (mul_done),
                .product (mul_product)
            );
        end else begin : g_no_mul
            assign mul_done    = 1'b0;
            assign mul_product = '0;
        end
    endgenerate

    assign neg     = display[WIDTH-1];
    assign busy    = (state == ST_MUL_RUN);
    assign op_pend = pend_op;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_ENTRY;
            pend_op  <= OP_NONE;
            fin_pend <= OP_NONE;
            key_q    <= 1'b0;
            fresh    <= 1'b0;
            fin_eq   <= 1'b0;
            mul_neg  <= 1'b0;
            entry    <= '0;
            operand  <= '0;
            display  <= '0;
            ovf      <= 1'b0;
        end else begin
            key_q <= key_valid;
            case (state)
                ST_ENTRY: begin
                    if (key_ev) begin
                        if (is_digit) begin
                            if (fresh) begin
                                entry   <= WIDTH'(key_code);
                                display <= WIDTH'(key_code);
                                fresh   <= 1'b0;
                            end else if (digit_ok) begin
                                entry   <= digit_acc[WIDTH-1:0];
                                display <= digit_acc[WIDTH-1:0];
                            end else begin
                                display <= entry;
                            end
                        end else if (key_code == KEY_CE) begin
                            entry   <= '0;
                            display <= '0;
                            ovf     <= 1'b0;
                        end else if (key_code == KEY_AC) begin
                            pend_op <= OP_NONE;
                            fresh   <= 1'b0;
                            entry   <= '0;
                            operand <= '0;
                            display <= '0;
                            ovf     <= 1'b0;
                        end else if (is_op) begin
                            if (correction) begin
                                pend_op <= next_op;
                            end else if (pend_op == OP_NONE) begin
                                operand <= entry;
                                display <= entry;
                                pend_op <= next_op;
                                fresh   <= 1'b1;
                            end else if (pend_op == OP_MUL) begin
                                // Result and pending-op update land when the multiplier finishes.
                                state    <= ST_MUL_RUN;
                                mul_neg  <= operand[WIDTH-1] ^ entry[WIDTH-1];
                                fin_eq   <= is_eq;
                                fin_pend <= next_op;
                            end else begin
                                operand <= addsub_res;
                                display <= addsub_res;
                                if (is_eq) begin
                                    entry <= addsub_res;
                                end
                                pend_op <= next_op;
                                fresh   <= 1'b1;
                                if (addsub_ovf) begin
                                    ovf <= 1'b1;
                                end
                            end
                        end
                    end
                end
                ST_MUL_RUN: begin
                    if (mul_done) begin
                        operand <= mul_res;
                        display <= mul_res;
                        if (fin_eq) begin
                            entry <= mul_res;
                        end
                        pend_op <= fin_pend;
                        fresh   <= 1'b1;
                        if (mul_ovf) begin
                            ovf <= 1'b1;
                        end
                        state <= ST_ENTRY;
                    end
                end
                default: state <= ST_ENTRY;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_core_param.sv
// tb/tb_calc_core_param.sv - scoreboard bench for calc_core_param against an arithmetic reference model
module tb_calc_core_param;

    localparam int     W    = 16;
    localparam longint MAXP = (64'sd1 <<< (W-1)) - 64'sd1;
    localparam longint MINN = -(64'sd1 <<< (W-1));
    localparam longint MODV = 64'sd1 <<< W;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid;
    logic [3:0]   key_code;
    logic [W-1:0] display;
    logic         neg;
    logic         ovf;
    logic         busy;
    logic [1:0]   op_pend;

    calc_core_param #(
        .WIDTH      (W),
        .MUL_ENABLE (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_code   (key_code),
        .display    (display),
        .neg        (neg),
        .ovf        (ovf),
        .busy       (busy),
        .op_pend    (op_pend)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                      name, act, act, exp, exp, cyc);
    endfunction

    // kind 0: outputs settle after the edge at_cyc; kind 1: multiply starts at at_cyc
    // and busy must stay high for busy_cycles samples before the outputs are compared.
    typedef struct {
        int           kind;
        int           at_cyc;
        logic [W-1:0] disp;
        bit           ovf;
        logic [1:0]   pend;
        int           busy_cycles;
    } item_t;

    item_t sb[$];

    // Reference model: values kept as plain signed integers.
    longint m_entry, m_operand, m_disp;
    int     m_pend;
    bit     m_fresh, m_ovf;

    function automatic void model_clear();
        m_entry = 0; m_operand = 0; m_disp = 0; m_pend = 0; m_fresh = 0; m_ovf = 0;
    endfunction

    function automatic longint wrap(input longint x);
        longint m;
        m = x & (MODV - 64'sd1);
        if (m > MAXP) m = m - MODV;
        return m;
    endfunction

    function automatic longint arith(input int op, input longint a, input longint b);
        longint r;
        if (op == 1)      r = a + b;
        else if (op == 2) r = a - b;
        else              r = a * b;
        if (r > MAXP || r < MINN) m_ovf = 1;
        return wrap(r);
    endfunction

    // Returns 1 when the key starts a multiply.
    function automatic bit model_key(input logic [3:0] k);
        bit is_mul;
        int kv;
        int nop;
        is_mul = 0;
        kv = int'(k);
        if (kv <= 9) begin
            if (m_fresh) begin
                m_entry = kv;
                m_fresh = 0;
            end else if (m_entry * 10 + kv <= MAXP) begin
                m_entry = m_entry * 10 + kv;
            end
            m_disp = m_entry;
        end else if (kv == 14) begin
            m_entry = 0; m_disp = 0; m_ovf = 0;
        end else if (kv == 15) begin
            model_clear();
        end else begin
            nop = (kv == 13) ? 0 : kv - 9;
            if (m_fresh && m_pend != 0) begin
                m_pend = nop;
            end else begin
                if (m_pend != 0) begin
                    is_mul    = (m_pend == 3);
                    m_operand = arith(m_pend, m_operand, m_entry);
                end else begin
                    m_operand = m_entry;
                end
                if (kv == 13) m_entry = m_operand;
                m_pend  = nop;
                m_disp  = m_operand;
                m_fresh = 1;
            end
        end
        return is_mul;
    endfunction

    task automatic issue(input logic [3:0] k, output bit m);
        item_t it;
        key_valid = 1'b1;
        key_code  = k;
        m = model_key(k);
        it.kind        = m ? 1 : 0;
        it.at_cyc      = cyc + 1;
        it.disp        = m_disp[W-1:0];
        it.ovf         = m_ovf;
        it.pend        = 2'(m_pend);
        it.busy_cycles = W;
        sb.push_back(it);
    endtask

    task automatic press(input logic [3:0] k, input int hold, input int gap);
        bit m;
        issue(k, m);
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (gap + (m ? W + 2 : 0)) @(negedge clk);
    endtask

    task automatic keys(input string s);
        int ci;
        for (int i = 0; i < s.len(); i++) begin
            ci = int'(s[i]);
            press((ci <= 57) ? 4'(ci - 48) : 4'(ci - 55), 2, 2);
        end
    endtask

    // Equals that starts a multiply, with a key pressed while busy (must be dropped).
    task automatic press_mul_intrude(input logic [3:0] k, input logic [3:0] intruder);
        bit m;
        issue(k, m);
        @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        key_valid = 1'b1;
        key_code  = intruder;
        repeat (2) @(negedge clk);
        key_valid = 1'b0;
        repeat (W + 2) @(negedge clk);
    endtask

    // Key that starts a multiply, then rst sampled on the edge after "after" busy cycles.
    task automatic press_abort(input logic [3:0] k, input int after);
        item_t it;
        key_valid = 1'b1;
        key_code  = k;
        void'(model_key(k));
        it.kind        = 1;
        it.at_cyc      = cyc + 1;
        it.disp        = '0;
        it.ovf         = 1'b0;
        it.pend        = 2'd0;
        it.busy_cycles = after;
        sb.push_back(it);
        model_clear();
        @(negedge clk);
        key_valid = 1'b0;
        repeat (after - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic spot(input logic [W-1:0] d, input bit o, input logic [1:0] p);
        item_t it;
        it.kind        = 0;
        it.at_cyc      = cyc + 1;
        it.disp        = d;
        it.ovf         = o;
        it.pend        = p;
        it.busy_cycles = 0;
        sb.push_back(it);
        @(negedge clk);
    endtask

    initial begin : monitor
        item_t it;
        int    n;
        forever begin
            while (sb.size() == 0) @(negedge clk);
            it = sb.pop_front();
            if (cyc > it.at_cyc) check("sb_late", longint'(cyc), longint'(it.at_cyc));
            while (cyc < it.at_cyc) @(negedge clk);
            if (it.kind == 1) begin
                check("busy_rise", longint'(busy), 1);
                n = 0;
                while (busy === 1'b1 && n < 4 * W) begin
                    n++;
                    @(negedge clk);
                end
                check("busy_len", longint'(n), longint'(it.busy_cycles));
            end
            check("display", longint'(display), longint'(it.disp));
            check("neg",     longint'(neg),     longint'(it.disp[W-1]));
            check("ovf",     longint'(ovf),     longint'(it.ovf));
            check("op_pend", longint'(op_pend), longint'(it.pend));
            check("busy",    longint'(busy),    0);
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int r;
        rst       = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_clear();
        repeat (3) @(negedge clk);
        spot('0, 1'b0, 2'd0);
        rst = 1'b0;
        @(negedge clk);

        press(4'h1, 10, 3);
        press(4'h2, 10, 3);
        press(4'h3, 10, 3);
        spot(W'(123), 1'b0, 2'd0);
        keys("F");

        keys("12A30D");
        spot(W'(42), 1'b0, 2'd0);
        keys("B50D");
        spot(16'hFFF8, 1'b0, 2'd0);
        keys("F");

        keys("123C45");
        press_mul_intrude(4'hD, 4'h7);
        spot(W'(5535), 1'b0, 2'd0);
        keys("F");

        keys("300C300D");
        spot(16'h5F90, 1'b1, 2'd0);
        keys("E");
        spot('0, 1'b0, 2'd0);
        keys("F32767A1D");
        spot(16'h8000, 1'b1, 2'd0);
        keys("F");

        keys("40000");
        spot(W'(4000), 1'b0, 2'd0);
        keys("F5AB2D");
        spot(W'(3), 1'b0, 2'd0);
        keys("F");

        keys("12C3");
        press_abort(4'hD, 5);
        keys("7D");
        spot(W'(7), 1'b0, 2'd0);

        keys("F");
        for (int i = 0; i < 250; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      press(4'($urandom_range(0, 9)),   $urandom_range(1, 4), $urandom_range(1, 3));
            else if (r < 88) press(4'($urandom_range(10, 13)), $urandom_range(1, 4), $urandom_range(1, 3));
            else if (r < 96) press(4'hE, $urandom_range(1, 4), $urandom_range(1, 3));
            else             press(4'hF, $urandom_range(1, 4), $urandom_range(1, 3));
        end

        repeat (W + 5) @(negedge clk);
        check("sb_drained", longint'(sb.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/calc_core_param.md
Name: calc_core_param

Overview:
Parametrised successor of the keypad calculator core behind the Tiny Tapeout top. It takes 4-bit keypad codes with a key-valid level and accepts signed decimal operands of configurable width. It supports chained left-to-right add/sub/mul, with multiply done by an iterative shift-add sub-unit. It drives a WIDTH-bit two's-complement display bus plus status flags; the top maps the bus onto uo_out/uio_out.

Parameters:
WIDTH, 16, operand/result width in bits (signed two's complement), legal 8..24
MUL_ENABLE, 1, 1 = multiply key active; 0 = multiply key ignored and no multiplier instantiated

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
key_valid  input  1  level, high while a key is held
key_code  input  4  keypad code, stable while key_valid high
display  output  WIDTH  value shown: current entry or last result, two's complement
neg  output  1  display[WIDTH-1]
ovf  output  1  sticky overflow flag
busy  output  1  multiply in progress; key events dropped
op_pend  output  2  pending operator: 0 none, 1 add, 2 sub, 3 mul

Behaviour:
- One clock; reset is synchronous and active-high. rst high at an edge clears entry, operand, pend_op, fresh, ovf, busy, display and the key_q sampler to 0. This applies mid-multiply too: the multiplier aborts and outputs are 0 after that edge.
- Key event: key_valid=1 && key_q=0, where key_q is key_valid registered. One event per press regardless of hold length.
- Events while busy=1 are discarded, not queued.
- All non-multiply effects are visible after the edge that samples the event (1-cycle latency).
- Key codes:
  - 0-9 digit
  - A add
  - B sub
  - C mul
  - D equals
  - E clear-entry
  - F all-clear
- Digit:
  - If fresh=1: entry=digit and fresh=0.
  - Else: entry=entry*10+digit, only if the result is ≤ 2^(WIDTH-1)-1. Otherwise the digit is ignored and entry is unchanged.
  - display=entry.
- Operator A/B/C:
  - If pend_op=none: operand=entry.
  - Else: operand = operand (pend_op) entry.
  - Then pend_op=new op, display=operand, fresh=1.
- Equals D:
  - Applies pend_op as above, then entry=operand, pend_op=none, display=result, fresh=1.
  - With pend_op=none, display=entry.
- Add/sub: single cycle, result wraps mod 2^WIDTH. Signed overflow sets ovf.
- Mul:
  - The edge sampling the event latches magnitudes and signs and raises busy.
  - busy stays high exactly WIDTH cycles.
  - On the edge that drops busy, display = low WIDTH bits of the signed product and the pending-op update completes.
  - ovf is set if the true product lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- ovf is sticky; cleared only by E, F or rst.
- E: entry=0, display=0, ovf=0. operand and pend_op are kept.
- F: same as reset except key_q.
- A/B/C/D event with fresh=1 and pend_op≠none replaces pend_op only (operator correction); no arithmetic is performed.
- C with MUL_ENABLE=0: ignored entirely.

States:
- ENTRY: default; digits and operators are processed.
- MUL_RUN: busy=1, iteration counter 0..WIDTH-1.
- Transitions:
  - ENTRY→MUL_RUN on an op/equals event needing mul.
  - MUL_RUN→ENTRY when the counter reaches WIDTH-1.
  - Any state→ENTRY on rst.

Decomposition:
- Package calc_pkg holds:
  - key code constants: KEY_ADD=4'hA, KEY_SUB=4'hB, KEY_MUL=4'hC, KEY_EQ=4'hD, KEY_CE=4'hE, KEY_AC=4'hF
  - op encoding: OP_NONE/ADD/SUB/MUL
  - state encoding: ST_ENTRY/ST_MUL_RUN
- Sub-module calc_mul_seq: unsigned WIDTH x WIDTH iterative shift-add multiplier.
  - Ports: start, a, b, done, product[2*WIDTH-1:0].
  - The core applies sign and overflow check.

Test Plan:
- WIDTH=16. Keys 1,2,3, each held 10 cycles → one digit per press; display=123, op_pend=0.
- 1,2,A,3,0,D → display=42. Then B,5,0,D → display=0xFFF8 (-8), neg=1, ovf=0.
- 1,2,3,C,4,5,D → busy high exactly 16 cycles, key pressed during busy ignored; display=5535 when busy falls.
- 3,0,0,C,3,0,0,D → ovf=1, display=0x5F90. Then E → ovf=0, display=0. Also 3,2,7,6,7,A,1,D → display=0x8000, ovf=1.
- Digit clamp: 4,0,0,0,0 → display=4000 (fifth digit ignored). Operator correction: 5,A,B,2,D → display=3.
- rst asserted mid-multiply (cycle 5 of busy) → all outputs 0 next edge. Then 7,D → display=7, op_pend=0.
